// File: rtl/register_file_pkg.sv
// ============================================================================
// Module : register_file_pkg
// Brief  : Shared MIPS register-file widths, well-known register indices and
//          the saturating write-counter helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package register_file_pkg;
  localparam int DATA_W_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT = 5;
  localparam int CNT_W          = 16;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction
endpackage

`default_nettype wire

// File: rtl/register_file_read_port.sv
// ============================================================================
// Module : register_file_read_port
// Brief  : One combinational read port; $zero forced to 0, optional bypass of
//          the data currently being written.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic [ADDR_W-1:0]                   i_addr,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]  i_regs,
  input  logic                                i_byp_en,
  input  logic [ADDR_W-1:0]                   i_byp_addr,
  input  logic [DATA_W-1:0]                   i_byp_data,
  output logic [DATA_W-1:0]                   o_data
);

  always_comb begin
    o_data = i_regs[i_addr];
    if (i_addr == ADDR_W'(REG_ZERO)) begin
      o_data = '0;
    end else if (i_byp_en && (i_byp_addr == i_addr)) begin
      o_data = i_byp_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// Module : register_file
// Brief  : MIPS 2**ADDR_W x DATA_W register file, two read ports, one write
//          port, debug read port and a saturating committed-write counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module register_file
  import register_file_pkg::*;
#(
  parameter int                 DATA_W    = DATA_W_DEFAULT,
  parameter int                 ADDR_W    = ADDR_W_DEFAULT,
  parameter int                 BYPASS    = 1,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               RegWrite,
  input  logic [ADDR_W-1:0]  WriteRegister,
  input  logic [DATA_W-1:0]  WriteData,
  input  logic [ADDR_W-1:0]  ReadRegister1,
  input  logic [ADDR_W-1:0]  ReadRegister2,
  output logic [DATA_W-1:0]  ReadData1,
  output logic [DATA_W-1:0]  ReadData2,
  input  logic [ADDR_W-1:0]  DebugAddr,
  output logic [DATA_W-1:0]  DebugData,
  output logic [CNT_W-1:0]   WriteCount
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] r_regs;
  logic [CNT_W-1:0]             r_count;
  logic                         w_we;
  logic                         w_byp_en;

  // Case equality keeps an X/Z enable from ever committing a write.
  assign w_we     = (RegWrite === 1'b1) && (WriteRegister != ADDR_W'(REG_ZERO));
  assign w_byp_en = (BYPASS != 0) && w_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= RESET_VAL;
      end
      r_count <= '0;
    end else if (w_we) begin
      r_regs[WriteRegister] <= WriteData;
      r_count               <= sat_inc(r_count);
    end
  end

  assign WriteCount = r_count;

  register_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
    .i_addr     (ReadRegister1),
    .i_regs     (r_regs),
    .i_byp_en   (w_byp_en),
    .i_byp_addr (WriteRegister),
    .i_byp_data (WriteData),
    .o_data     (ReadData1)
  );

  register_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
    .i_addr     (ReadRegister2),
    .i_regs     (r_regs),
    .i_byp_en   (w_byp_en),
    .i_byp_addr (WriteRegister),
    .i_byp_data (WriteData),
    .o_data     (ReadData2)
  );

  register_file_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dbg (
    .i_addr     (DebugAddr),
    .i_regs     (r_regs),
    .i_byp_en   (1'b0),
    .i_byp_addr (WriteRegister),
    .i_byp_data (WriteData),
    .o_data     (DebugData)
  );

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// Bench for register_file: BYPASS=1 and BYPASS=0 instances share stimulus and
// are compared against an array model every cycle, plus directed literal checks.
`default_nettype none

module tb_register_file;
  logic        clk;
  logic        rst_n;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [4:0]  DebugAddr;
  logic [31:0] rd1_b, rd2_b, dbg_b, rd1_n, rd2_n, dbg_n;
  logic [15:0] cnt_b, cnt_n;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] m [32];
  int          m_cnt;

  register_file #(.BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(rd1_b), .ReadData2(rd2_b), .DebugAddr(DebugAddr), .DebugData(dbg_b),
    .WriteCount(cnt_b)
  );

  register_file #(.BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(rd1_n), .ReadData2(rd2_n), .DebugAddr(DebugAddr), .DebugData(dbg_n),
    .WriteCount(cnt_n)
  );

  initial begin
    clk = 1'b0;
    #2;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: plain array plus saturating counter.
  initial begin
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    m_cnt = 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m[i] = 32'h0;
      m_cnt = 0;
    end else if (RegWrite === 1'b1 && WriteRegister != 5'd0) begin
      m[WriteRegister] = WriteData;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end
  end

  function automatic logic [31:0] exp_read(input logic [4:0] ra, input bit byp);
    if (ra == 5'd0) return 32'h0;
    if (byp && RegWrite === 1'b1 && WriteRegister != 5'd0 && WriteRegister == ra)
      return WriteData;
    return m[ra];
  endfunction

  always @(negedge clk) begin
    check("rd1_byp", rd1_b, exp_read(ReadRegister1, 1'b1));
    check("rd2_byp", rd2_b, exp_read(ReadRegister2, 1'b1));
    check("rd1_nob", rd1_n, exp_read(ReadRegister1, 1'b0));
    check("rd2_nob", rd2_n, exp_read(ReadRegister2, 1'b0));
    check("dbg_byp", dbg_b, exp_read(DebugAddr, 1'b0));
    check("dbg_nob", dbg_n, exp_read(DebugAddr, 1'b0));
    check("cnt_byp", {16'h0, cnt_b}, m_cnt[31:0]);
    check("cnt_nob", {16'h0, cnt_n}, m_cnt[31:0]);
  end

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    RegWrite = 1'b1; WriteRegister = a; WriteData = d;
    @(posedge clk); #1;
    RegWrite = 1'b0;
  endtask

  logic       RegDst;
  logic [4:0] rt, rd;

  initial begin
    rst_n = 1'b0; RegWrite = 1'b0; WriteRegister = 5'd0; WriteData = 32'h0;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0; DebugAddr = 5'd0;
    RegDst = 1'b0; rt = 5'd4; rd = 5'd6;
    #15 rst_n = 1'b1;

    // Reset state of every register through the debug port
    for (int i = 0; i < 32; i++) begin
      DebugAddr = 5'(i); #0.1;
      check("reset_dbg", dbg_b, 32'h0);
    end
    check("reset_cnt", {16'h0, cnt_b}, 32'd0);

    wr(5'd6, 32'hDEADBEEF);
    ReadRegister1 = 5'd6; #1;
    check("basic_rd1", rd1_b, 32'hDEADBEEF);
    check("basic_cnt", {16'h0, cnt_b}, 32'd1);

    wr(5'd0, 32'h12345678);
    ReadRegister2 = 5'd0; #1;
    check("zero_rd2", rd2_b, 32'h0);
    check("zero_cnt", {16'h0, cnt_b}, 32'd1);

    wr(5'd4, 32'h1);
    @(posedge clk); #1;
    RegWrite = 1'b1; WriteRegister = 5'd4; WriteData = 32'hA5A5A5A5;
    ReadRegister1 = 5'd4; ReadRegister2 = 5'd4; #1;
    check("byp_rd1", rd1_b, 32'hA5A5A5A5);
    check("byp_rd2", rd2_b, 32'hA5A5A5A5);
    check("nobyp_rd1", rd1_n, 32'h1);
    check("nobyp_rd2", rd2_n, 32'h1);
    @(posedge clk); #1;
    RegWrite = 1'b0; #1;
    check("nobyp_after", rd1_n, 32'hA5A5A5A5);
    check("cnt_after_byp", {16'h0, cnt_b}, 32'd3);

    wr(5'd9, 32'h77);
    DebugAddr = 5'd9; #1;
    check("r9_pre", dbg_b, 32'h77);
    @(posedge clk); #1;
    RegWrite = 1'b1; WriteRegister = 5'd9; WriteData = 32'hFF;
    #7 rst_n = 1'b0;
    #1;
    check("rst_mid_byp", dbg_b, 32'h0);
    check("rst_mid_nob", dbg_n, 32'h0);
    @(posedge clk); #1;
    check("rst_post_edge", dbg_b, 32'h0);
    check("rst_post_cnt", {16'h0, cnt_b}, 32'd0);
    RegWrite = 1'b0;
    #2 rst_n = 1'b1;

    // RegDst mux selects rd (1) or rt (0) as the destination
    wr(5'd4, 32'h44);
    RegDst = 1'b1;
    wr(RegDst ? rd : rt, 32'hCAFE);
    DebugAddr = 5'd6; #1;
    check("regdst1_r6", dbg_b, 32'hCAFE);
    DebugAddr = 5'd4; #1;
    check("regdst1_r4", dbg_b, 32'h44);
    RegDst = 1'b0;
    wr(RegDst ? rd : rt, 32'hCAFE);
    DebugAddr = 5'd4; #1;
    check("regdst0_r4", dbg_b, 32'hCAFE);
    check("regdst_cnt", {16'h0, cnt_b}, 32'd3);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
